// File: rtl/bus_pkg.sv
// Shared types and helpers for the data-bus RAM responder.
package bus_pkg;

  localparam int unsigned BUS_ADDR_W = 32;
  localparam int unsigned BUS_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } bus_resp_state_t;

  // Request captured at acceptance and replayed through WAIT/RESP
  typedef struct packed {
    logic                  we;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wdata;
    logic                  hit;
  } bus_req_t;

  // Word offset of a byte address from the window base; caller truncates
  function automatic logic [BUS_ADDR_W-1:0] word_index(input logic [BUS_ADDR_W-1:0] addr,
                                                       input logic [BUS_ADDR_W-1:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/ram_sp_sync.sv
// Single-port synchronous RAM: one write and one registered read per clock, array not reset.
module ram_sp_sync #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/bus_ram_responder.sv
// Data-bus responder: word RAM behind a single-request handshake with programmable wait states
// and out-of-window error reporting.
module bus_ram_responder
  import bus_pkg::*;
#(
  parameter logic [BUS_ADDR_W-1:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned           DEPTH_WORDS = 256,
  parameter int unsigned           WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bus_req,
  input  logic                  bus_we,
  input  logic [BUS_ADDR_W-1:0] bus_addr,
  input  logic [BUS_DATA_W-1:0] bus_wdata,
  output logic [BUS_DATA_W-1:0] bus_rdata,
  output logic                  bus_ready,
  output logic                  bus_err,
  output logic                  busy
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 4;
  localparam logic [BUS_ADDR_W:0] LIMIT =
    {1'b0, BASE_ADDR} + (BUS_ADDR_W + 1)'(4 * DEPTH_WORDS);
  localparam logic [CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES == 0) ? CNT_W'(0) : CNT_W'(WAIT_CYCLES - 1);

  bus_resp_state_t state, state_next;
  logic [CNT_W-1:0] cnt_q, cnt_next;
  bus_req_t         req_q, req_next;
  logic             ready_next, err_next, busy_next;
  logic [BUS_DATA_W-1:0] rdata_q;
  logic [BUS_DATA_W-1:0] ram_rdata;
  logic [IDX_W-1:0]      ram_addr;
  logic                  ram_we;
  logic                  hit_c;

  // Unsigned window check widened by one bit so the top of the window never wraps
  assign hit_c = (bus_addr >= BASE_ADDR) && ({1'b0, bus_addr} < LIMIT);

  always_comb begin
    state_next = state;
    cnt_next   = cnt_q;
    req_next   = req_q;
    unique case (state)
      IDLE: begin
        if (bus_req) begin
          req_next = '{we: bus_we, addr: bus_addr, wdata: bus_wdata, hit: hit_c};
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(0)) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    ready_next = (state_next == RESP);
    busy_next  = (state_next != IDLE);
    err_next   = (state_next == RESP) && !req_next.hit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt_q     <= '0;
      req_q     <= '0;
      bus_ready <= 1'b0;
      bus_err   <= 1'b0;
      busy      <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state     <= state_next;
      cnt_q     <= cnt_next;
      req_q     <= req_next;
      bus_ready <= ready_next;
      bus_err   <= err_next;
      busy      <= busy_next;
      rdata_q   <= bus_rdata;
    end
  end

  // RAM sees the live address while idle so a zero-wait read is ready on the RESP edge
  assign ram_addr = (state == IDLE) ? IDX_W'(word_index(bus_addr, BASE_ADDR))
                                    : IDX_W'(word_index(req_q.addr, BASE_ADDR));
  assign ram_we   = (state == RESP) && req_q.we && req_q.hit;

  ram_sp_sync #(
    .DEPTH  (DEPTH_WORDS),
    .ADDR_W (IDX_W),
    .DATA_W (BUS_DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (req_q.wdata),
    .rdata (ram_rdata)
  );

  // Read data presented in RESP; writes and idle cycles hold the last value shown
  always_comb begin
    bus_rdata = rdata_q;
    if (state == RESP && !req_q.we) begin
      bus_rdata = req_q.hit ? ram_rdata : '0;
    end
  end

endmodule

// File: tb/tb_bus_ram_responder.sv
// Directed bench for bus_ram_responder with WAIT_CYCLES = 0, 1 and 3 instances side by side.
module tb_bus_ram_responder;

  logic        clk;
  logic        reset;
  logic [2:0]  req, we, ready, err, busy;
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  int          wc [3] = '{0, 1, 3};
  int          checks;
  int          failures;

  bus_ram_responder #(.BASE_ADDR(32'h1000_0000), .DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .bus_req(req[0]), .bus_we(we[0]), .bus_addr(addr[0]),
    .bus_wdata(wdata[0]), .bus_rdata(rdata[0]), .bus_ready(ready[0]), .bus_err(err[0]),
    .busy(busy[0]));

  bus_ram_responder #(.BASE_ADDR(32'h1000_0000), .DEPTH_WORDS(256), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .bus_req(req[1]), .bus_we(we[1]), .bus_addr(addr[1]),
    .bus_wdata(wdata[1]), .bus_rdata(rdata[1]), .bus_ready(ready[1]), .bus_err(err[1]),
    .busy(busy[1]));

  bus_ram_responder #(.BASE_ADDR(32'h1000_0000), .DEPTH_WORDS(256), .WAIT_CYCLES(3)) dut2 (
    .clk(clk), .reset(reset), .bus_req(req[2]), .bus_we(we[2]), .bus_addr(addr[2]),
    .bus_wdata(wdata[2]), .bus_rdata(rdata[2]), .bus_ready(ready[2]), .bus_err(err[2]),
    .busy(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access: present at an edge boundary, count edges until bus_ready, check result and pulse width
  task automatic xact(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic chk_rd, input logic [31:0] exp_rd, input logic exp_err,
                      input string tag);
    int k;
    k = 0;
    @(posedge clk); #1;
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
    while (k < 20) begin
      @(posedge clk); #1;
      k++;
      if (k == 1) req[d] = 1'b0;
      if (ready[d]) break;
    end
    chk({tag, "_lat"}, 32'(k), 32'(wc[d] + 1));
    chk({tag, "_err"}, 32'(err[d]), 32'(exp_err));
    if (chk_rd) chk({tag, "_rdata"}, rdata[d], exp_rd);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 32'(ready[d]), 32'd0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    req = '0;
    we = '0;
    for (int d = 0; d < 3; d++) begin
      addr[d] = '0;
      wdata[d] = '0;
    end

    #12;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_ready%0d", d), 32'(ready[d]), 32'd0);
      chk($sformatf("rst_err%0d", d), 32'(err[d]), 32'd0);
      chk($sformatf("rst_busy%0d", d), 32'(busy[d]), 32'd0);
      chk($sformatf("rst_rdata%0d", d), rdata[d], 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    // WAIT_CYCLES=1: write/read, holds on write, misses, aliasing, top-of-window
    xact(1, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, "w1_wr10");
    xact(1, 1'b0, 32'h1000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, "w1_rd10");
    xact(1, 1'b1, 32'h1000_0000, 32'hCAFE_0000, 1'b1, 32'hDEAD_BEEF, 1'b0, "w1_wr00");
    xact(1, 1'b1, 32'h1000_0400, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF, 1'b1, "w1_wrmiss");
    xact(1, 1'b0, 32'h1000_0000, 32'h0,         1'b1, 32'hCAFE_0000, 1'b0, "w1_noalias");
    xact(1, 1'b0, 32'h0FFF_FFFC, 32'h0,         1'b1, 32'h0, 1'b1, "w1_rdlow");
    xact(1, 1'b0, 32'h1000_0400, 32'h0,         1'b1, 32'h0, 1'b1, "w1_rdhigh");
    xact(1, 1'b1, 32'h1000_03FC, 32'h0BAD_F00D, 1'b0, 32'h0, 1'b0, "w1_wrtop");
    xact(1, 1'b0, 32'h1000_03FC, 32'h0,         1'b1, 32'h0BAD_F00D, 1'b0, "w1_rdtop");

    // Held request: pulses every 3 cycles, address change during WAIT ignored
    @(posedge clk); #1;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h1000_0010;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 1) addr[1] = 32'h1000_0000;
      chk($sformatf("hold_rdy%0d", k), 32'(ready[1]), 32'((k % 3) == 2));
      if (k == 2) chk("hold_rd_first", rdata[1], 32'hDEAD_BEEF);
      if (k == 5 || k == 8) chk($sformatf("hold_rd%0d", k), rdata[1], 32'hCAFE_0000);
    end
    req[1] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // WAIT_CYCLES=0 and 3 latency
    xact(0, 1'b1, 32'h1000_0000, 32'h0000_00A0, 1'b0, 32'h0, 1'b0, "w0_wr00");
    xact(0, 1'b0, 32'h1000_0000, 32'h0,         1'b1, 32'h0000_00A0, 1'b0, "w0_rd00");
    xact(2, 1'b1, 32'h1000_0000, 32'h0000_00A3, 1'b0, 32'h0, 1'b0, "w3_wr00");
    xact(2, 1'b0, 32'h1000_0000, 32'h0,         1'b1, 32'h0000_00A3, 1'b0, "w3_rd00");
    xact(2, 1'b1, 32'h1000_0008, 32'hA5A5_0008, 1'b0, 32'h0, 1'b0, "w3_wr08");

    // Reset during WAIT drops the pending write
    @(posedge clk); #1;
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h1000_0008; wdata[2] = 32'h1111_1111;
    @(posedge clk); #1;
    req[2] = 1'b0;
    chk("rstwait_busy", 32'(busy[2]), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("rstwait_busy_clr", 32'(busy[2]), 32'd0);
    chk("rstwait_ready_clr", 32'(ready[2]), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rstwait_rdata_clr", rdata[2], 32'd0);
    xact(2, 1'b0, 32'h1000_0008, 32'h0, 1'b1, 32'hA5A5_0008, 1'b0, "w3_rd08_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
